// File: rtl/alu_pkg.sv
// Shared types for the ALU issuer: opcodes, NZCV flag layout and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_DIV = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } issuer_state_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x WIDTH, two combinational read ports, two write
// ports. Port 0 (writeback) wins over port 1 (load) on the same address.
module alu_regfile #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en0,
  input  logic [AW-1:0]    wr_addr0,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic             wr_en1,
  input  logic [AW-1:0]    wr_addr1,
  input  logic [WIDTH-1:0] wr_data1
);
  import alu_pkg::*;

  logic [WIDTH-1:0] mem [NREGS];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  // Per-entry write with writeback priority over the load port.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (!rst_n) begin
        mem[i] <= '0;
      end else if (wr_en0 && wr_addr0 == AW'(i)) begin
        mem[i] <= wr_data0;
      end else if (wr_en1 && wr_addr1 == AW'(i)) begin
        mem[i] <= wr_data1;
      end
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// Sequential front end for the combinational 4-bit ALU: accepts a command,
// presents registered operands, captures result/flags, writes back and
// returns a response. Optional macro ALU_ISSUER_STATS_EN adds saturating
// op/error counters (stat_ops, stat_errs).
module alu_issuer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [AW-1:0]    cmd_rd,
  input  logic             cmd_setflags,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [3:0]       flags_q
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_errs
`endif
);
  import alu_pkg::*;

  issuer_state_t    state;
  logic [AW-1:0]    rd_q;
  logic             setflags_q;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             err;
  logic             wb_en;
  alu_flags_t       alu_flags;

  assign alu_flags = '{n: alu_negative, z: alu_zero, c: alu_carry, v: alu_overflow};
  assign err       = (alu_op_t'(alu_control) == OP_DIV) && (alu_b == '0);
  assign wb_en     = (state == EXEC) && !err;

  alu_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (cmd_ra),
    .rd_data_a (ra_data),
    .rd_addr_b (cmd_rb),
    .rd_data_b (rb_data),
    .wr_en0    (wb_en),
    .wr_addr0  (rd_q),
    .wr_data0  (alu_result),
    .wr_en1    (load_en),
    .wr_addr1  (load_addr),
    .wr_data1  (load_data)
  );

  // Issue FSM: IDLE accepts, EXEC captures ALU output, RESP holds response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rd_q        <= '0;
      setflags_q  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_err     <= 1'b0;
      flags_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a       <= ra_data;
            alu_b       <= rb_data;
            alu_control <= cmd_op;
            rd_q        <= cmd_rd;
            setflags_q  <= cmd_setflags;
            cmd_ready   <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_flags <= alu_flags;
          rsp_valid <= 1'b1;
          if (err) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_result;
            rsp_err  <= 1'b0;
            if (setflags_q) begin
              flags_q <= alu_flags;
            end
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  // Saturating counters of completed operations and division-by-zero errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (state == EXEC) begin
      if (stat_ops != STAT_MAX) begin
        stat_ops <= stat_ops + 16'd1;
      end
      if (err && stat_errs != STAT_MAX) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`endif

endmodule
